// File: rtl/byte_uart_pkg.sv
// Shared state codes, parity modes and the parity helper for the byte UART transmitter.
package byte_uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Even parity makes the total count of ones even; odd parity is its complement.
    function automatic logic parity_of(input logic [7:0] data, input int mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/byte_uart_tx_baud_tick_gen.sv
// Bit-period down-counter: reload on load, tick while the count sits at zero.
module baud_tick_gen #(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/byte_uart_tx.sv
// Byte-to-UART serialiser: valid/ready byte input, registered idle-high tx line.
module byte_uart_tx
    import byte_uart_pkg::*;
#(
    parameter int CLK_DIV   = 10,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy
);

    logic [2:0] state;
    logic [7:0] shift_reg;
    logic [2:0] bit_idx;
    logic       stop_idx;
    logic       par_bit;
    logic       tick;
    logic       transfer;
    logic       advance;

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);
    assign transfer = in_valid && in_ready;
    assign advance  = busy && tick;

    // Every state change restarts the bit period, including the IDLE -> START entry.
    baud_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .load (transfer || advance),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tx        <= 1'b1;
            shift_reg <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            par_bit   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (transfer) begin
                        state     <= ST_START;
                        tx        <= 1'b0;
                        shift_reg <= in_data;
                        par_bit   <= parity_of(in_data, PARITY);
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state     <= ST_DATA;
                        tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_idx   <= '0;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'd7) begin
                            if (PARITY != PAR_NONE) begin
                                state <= ST_PARITY;
                                tx    <= par_bit;
                            end else begin
                                state    <= ST_STOP;
                                tx       <= 1'b1;
                                stop_idx <= 1'b0;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state    <= ST_STOP;
                        tx       <= 1'b1;
                        stop_idx <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (STOP_BITS == 1 || stop_idx) begin
                            state <= ST_IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_uart_tx.sv
// Bench for byte_uart_tx: four parameterisations side by side, frames checked against a bit-list model.
module tb_byte_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din [4];
    logic [3:0] vin;
    logic [3:0] rdy;
    logic [3:0] txw;
    logic [3:0] bsy;

    int vectors     = 0;
    int miscompares = 0;

    int cdiv [4] = '{4, 4, 4, 2};
    int par  [4] = '{0, 1, 2, 0};
    int stp  [4] = '{1, 1, 1, 2};

    always #5 clk = ~clk;

    byte_uart_tx #(.CLK_DIV(4), .PARITY(0), .STOP_BITS(1)) dut_none (
        .clk(clk), .rst_n(rst_n), .in_data(din[0]), .in_valid(vin[0]),
        .in_ready(rdy[0]), .tx(txw[0]), .busy(bsy[0]));
    byte_uart_tx #(.CLK_DIV(4), .PARITY(1), .STOP_BITS(1)) dut_even (
        .clk(clk), .rst_n(rst_n), .in_data(din[1]), .in_valid(vin[1]),
        .in_ready(rdy[1]), .tx(txw[1]), .busy(bsy[1]));
    byte_uart_tx #(.CLK_DIV(4), .PARITY(2), .STOP_BITS(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .in_data(din[2]), .in_valid(vin[2]),
        .in_ready(rdy[2]), .tx(txw[2]), .busy(bsy[2]));
    byte_uart_tx #(.CLK_DIV(2), .PARITY(0), .STOP_BITS(2)) dut_stop2 (
        .clk(clk), .rst_n(rst_n), .in_data(din[3]), .in_valid(vin[3]),
        .in_ready(rdy[3]), .tx(txw[3]), .busy(bsy[3]));

    function automatic int frame_len(int i);
        return (1 + 8 + ((par[i] != 0) ? 1 : 0) + stp[i]) * cdiv[i];
    endfunction

    // Frame as a list of bit slots: start, 8 data LSB first, optional parity, stops.
    function automatic logic exp_bit(int i, logic [7:0] b, int k);
        int n;
        n = k / cdiv[i];
        if (n == 0) return 1'b0;
        if (n <= 8) return b[n-1];
        if (par[i] != 0 && n == 9) return (par[i] == 1) ? ^b : ~^b;
        return 1'b1;
    endfunction

    task automatic drive_start(int i, logic [7:0] b);
        @(negedge clk);
        din[i] = b;
        vin[i] = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        vin   = '0;
        for (int i = 0; i < 4; i++) din[i] = 8'hxx;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (txw[i] !== 1'b1 || bsy[i] !== 1'b0 || rdy[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset dut%0d: tx=%b busy=%b rdy=%b, expected tx=1 busy=0 rdy=1",
                         i, txw[i], bsy[i], rdy[i]);
            end
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (txw[i] !== 1'b1 || bsy[i] !== 1'b0 || rdy[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL idle_after_reset dut%0d: tx=%b busy=%b rdy=%b, expected 1/0/1",
                         i, txw[i], bsy[i], rdy[i]);
            end
        end
    endtask

    task automatic test_fixed_a5();
        logic [9:0] seq;
        logic [7:0] io_in;
        seq   = 10'b1101001010;
        io_in = 8'h5A;
        vectors++;
        if (rdy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL a5_ready_before: rdy=%b expected 1", rdy[0]);
        end
        drive_start(0, ~io_in);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            vectors++;
            if (txw[0] !== seq[k/4] || bsy[0] !== 1'b1 || rdy[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL a5_frame k=%0d: tx=%b busy=%b rdy=%b, expected tx=%b busy=1 rdy=0",
                         k, txw[0], bsy[0], rdy[0], seq[k/4]);
            end
            if (k == 0) vin[0] = 1'b0;
        end
        @(negedge clk);
        vectors++;
        if (txw[0] !== 1'b1 || bsy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL a5_end: tx=%b busy=%b rdy=%b, expected 1/0/1", txw[0], bsy[0], rdy[0]);
        end
    endtask

    task automatic test_parity();
        logic pexp;
        for (int i = 1; i <= 2; i++) begin
            pexp = (i == 1) ? 1'b1 : 1'b0;
            drive_start(i, 8'h07);
            for (int k = 0; k < 44; k++) begin
                @(negedge clk);
                vectors++;
                if (txw[i] !== exp_bit(i, 8'h07, k) || bsy[i] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL parity_frame dut%0d k=%0d: tx=%b busy=%b, expected tx=%b busy=1",
                             i, k, txw[i], bsy[i], exp_bit(i, 8'h07, k));
                end
                if (k / 4 == 9) begin
                    vectors++;
                    if (txw[i] !== pexp) begin
                        miscompares++;
                        $display("FAIL parity_bit dut%0d k=%0d: tx=%b expected %b", i, k, txw[i], pexp);
                    end
                end
                if (k == 0) vin[i] = 1'b0;
            end
            @(negedge clk);
            vectors++;
            if (bsy[i] !== 1'b0 || rdy[i] !== 1'b1 || txw[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL parity_end dut%0d: tx=%b busy=%b rdy=%b, expected 1/0/1",
                         i, txw[i], bsy[i], rdy[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive_start(0, 8'h00);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            vectors++;
            if (txw[0] !== exp_bit(0, 8'h00, k) || bsy[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_frame1 k=%0d: tx=%b busy=%b, expected tx=%b busy=1",
                         k, txw[0], bsy[0], exp_bit(0, 8'h00, k));
            end
            if (k == 0) din[0] = 8'hFF;
        end
        @(negedge clk);
        vectors++;
        if (txw[0] !== 1'b1 || rdy[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_gap: tx=%b rdy=%b busy=%b, expected 1/1/0", txw[0], rdy[0], bsy[0]);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            vectors++;
            if (txw[0] !== exp_bit(0, 8'hFF, k) || bsy[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_frame2 k=%0d: tx=%b busy=%b, expected tx=%b busy=1",
                         k, txw[0], bsy[0], exp_bit(0, 8'hFF, k));
            end
            if (k == 0) vin[0] = 1'b0;
        end
        @(negedge clk);
        vectors++;
        if (txw[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end: tx=%b busy=%b, expected 1/0", txw[0], bsy[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        drive_start(0, 8'h3C);
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            vectors++;
            if (txw[0] !== exp_bit(0, 8'h3C, k)) begin
                miscompares++;
                $display("FAIL abort_prefix k=%0d: tx=%b expected %b", k, txw[0], exp_bit(0, 8'h3C, k));
            end
            if (k == 0) vin[0] = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (txw[0] !== 1'b1 || bsy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_async: tx=%b busy=%b rdy=%b, expected 1/0/1", txw[0], bsy[0], rdy[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_start(0, 8'h81);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            vectors++;
            if (txw[0] !== exp_bit(0, 8'h81, k) || bsy[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL after_abort k=%0d: tx=%b busy=%b, expected tx=%b busy=1",
                         k, txw[0], bsy[0], exp_bit(0, 8'h81, k));
            end
            if (k == 0) vin[0] = 1'b0;
        end
        @(negedge clk);
        vectors++;
        if (txw[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL after_abort_end: tx=%b busy=%b, expected 1/0", txw[0], bsy[0]);
        end
    endtask

    task automatic test_stop2();
        drive_start(3, 8'h96);
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            vectors++;
            if (txw[3] !== exp_bit(3, 8'h96, k) || rdy[3] !== 1'b0 || bsy[3] !== 1'b1) begin
                miscompares++;
                $display("FAIL stop2_frame k=%0d: tx=%b rdy=%b busy=%b, expected tx=%b rdy=0 busy=1",
                         k, txw[3], rdy[3], bsy[3], exp_bit(3, 8'h96, k));
            end
            if (k == 0) vin[3] = 1'b0;
        end
        @(negedge clk);
        vectors++;
        if (rdy[3] !== 1'b1 || txw[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL stop2_end: rdy=%b tx=%b, expected 1/1", rdy[3], txw[3]);
        end
    endtask

    task automatic test_random();
        int         i;
        logic [7:0] b;
        for (int n = 0; n < 24; n++) begin
            i = $urandom_range(0, 3);
            b = 8'($urandom);
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                @(negedge clk);
                din[i] = 8'($urandom);
            end
            vectors++;
            if (rdy[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL rand_ready dut%0d: rdy=%b expected 1", i, rdy[i]);
            end
            drive_start(i, b);
            for (int k = 0; k < frame_len(i); k++) begin
                @(negedge clk);
                vectors++;
                if (txw[i] !== exp_bit(i, b, k) || bsy[i] !== 1'b1 || rdy[i] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rand_frame dut%0d byte=%02h k=%0d: tx=%b busy=%b rdy=%b, expected tx=%b busy=1 rdy=0",
                             i, b, k, txw[i], bsy[i], rdy[i], exp_bit(i, b, k));
                end
                if (k == 0) vin[i] = 1'b0;
                if (k == 1) din[i] = 8'($urandom);
            end
            @(negedge clk);
            vectors++;
            if (txw[i] !== 1'b1 || bsy[i] !== 1'b0 || rdy[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL rand_end dut%0d: tx=%b busy=%b rdy=%b, expected 1/0/1",
                         i, txw[i], bsy[i], rdy[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed_a5();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_stop2();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
